icache_dual_fetch: RTL
======================

Name: icache_dual_fetch

Overview:
- Instruction-side responder for the dual-issue fetch interface of mycpu.
- Accepts raddr_to_icache/rreq_to_icache and returns inst1/inst2 with their addresses, replacing the zero-latency inst_rom model.
- Direct-mapped, read-only, with a line-refill burst port toward memory.
- Sits between mycpu and the memory/bus bridge.

Parameters:
- SETS, 64, number of lines; power of 2, at least 2.
- LINE_WORDS, 8, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rreq_i  in  1  CPU fetch request (rreq_to_icache).
- raddr_i  in  32  fetch address (raddr_to_icache); bits [1:0] ignored.
- invalidate_i  in  1  one-cycle pulse: clear all valid bits.
- inst1_o  out  32  instruction at the latched address.
- inst2_o  out  32  instruction at the latched address + 4.
- inst1_addr_o  out  32  word-aligned address of inst1_o.
- inst2_addr_o  out  32  inst1_addr_o + 4.
- inst_valid_o  out  1  inst1 outputs valid this cycle.
- inst2_valid_o  out  1  inst2 outputs valid this cycle.
- stall_o  out  1  CPU must hold rreq_i/raddr_i stable.
- mem_req_o  out  1  line refill request.
- mem_addr_o  out  32  line-aligned refill address.
- mem_ack_i  in  1  refill request accepted.
- mem_rvalid_i  in  1  refill data beat valid.
- mem_rdata_i  in  32  refill data beat.

Behaviour:
- Reset (rst low, async): all valid bits 0, state IDLE, beat counter 0. All outputs 0 and all *_addr_o 0.
- Address split: word offset = addr[2+WO-1:2], with WO = log2(LINE_WORDS). Index is the next log2(SETS) bits; tag is the remaining upper bits.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE, or LOOKUP on a hit with no stall: if rreq_i, latch raddr_i and move to LOOKUP, else go to IDLE. If invalidate_i is high in the same cycle, the invalidate wins and the request is still latched.
- LOOKUP, hit (valid and tag match): in the same cycle drive inst_valid_o=1, inst1_o, and inst1_addr_o = latched address & ~3.
  - If offset < LINE_WORDS-1: inst2_valid_o=1 and inst2_o = next word of the same line.
  - Else: inst2_valid_o=0 and inst2_o=0, because there is no cross-line second fetch.
  - Hit latency: request at edge N, data valid in cycle N+1, one request per cycle sustained.
- LOOKUP, miss: stall_o=1 combinationally and go to MISS_REQ.
- MISS_REQ: mem_req_o=1 with mem_addr_o = latched address with the offset and byte bits zeroed.
  - Hold until mem_ack_i, then go to REFILL with counter=0. stall_o=1.
  - mem_rvalid_i is ignored in this state.
- REFILL: each mem_rvalid_i writes word[counter] of the indexed line, then counter++.
  - On the beat with counter==LINE_WORDS-1: write the tag, set valid, go to RESP. stall_o=1.
  - Beats are in ascending order from word 0.
- RESP: outputs are driven from the filled line exactly as on a hit, and stall_o=0. rreq_i is sampled as in IDLE.
- Miss latency: LOOKUP, plus MISS_REQ cycles, plus LINE_WORDS beats, plus 1 RESP cycle.
- While stall_o=1, rreq_i/raddr_i are not sampled.
- invalidate_i arriving in MISS_REQ or REFILL is latched. The refill completes and RESP delivers the data. The invalidate applies at the end of RESP, so the just-filled line also becomes invalid.
- When inst_valid_o=0, all data and address outputs hold their last values and inst2_valid_o=0.
- rst asserted mid-refill: the FSM returns to IDLE immediately and mem_req_o=0. The partial line stays invalid. The memory side shares rst.

Decomposition:
- Shared defines file: InstAddrBus/InstBus widths, the state encoding, and the derived geometry constants (WO, index width, tag width).
- One sub-module, icache_line_bank: the tag, valid and data arrays.
  - Single write port for refill beats, tag and valid.
  - Combinational read of two words from one line.
  - Bulk valid clear.

Test Plan:
- Cold miss at 0x00000100 (SETS=64, LINE_WORDS=8): mem_req_o with mem_addr_o=0x00000100. After ack, 8 beats 0x11..0x88; RESP gives inst1=0x11, inst2=0x22, inst2_addr=0x104, stall_o high from LOOKUP to the last beat.
- Back-to-back hits at 0x104, then 0x108: one result per cycle (0x22/0x33, then 0x33/0x44), stall_o=0, mem_req_o=0.
- Last-word fetch at 0x11C: inst1=0x88, inst2_valid_o=0, inst2_o=0.
- Conflict at 0x00000900 (same index, different tag): a new refill occurs. A later fetch at 0x100 misses again.
- invalidate_i pulsed during REFILL beat 3: RESP data is still correct, and the next fetch of the same line misses.
- rst low during beat 5: outputs go to 0 and state to IDLE. After release, a fetch of 0x100 misses and refills.

Source files
------------

// File: rtl/icache_dual_fetch_pkg.sv
// Shared widths, FSM encoding and line geometry helpers for the dual-fetch instruction cache.
package icache_dual_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESP
    } state_t;

    function automatic int geo_wo(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int geo_iw(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int geo_tw(input int sets, input int line_words);
        return INST_ADDR_W - 2 - $clog2(line_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_line_bank.sv
// Tag, valid and data storage: one write port for refill beats/tag, two-word combinational read of one line.
module icache_line_bank
    import icache_dual_fetch_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic [geo_iw(SETS)-1:0]              idx,
    input  logic [geo_wo(LINE_WORDS)-1:0]        rword,
    output logic [INST_W-1:0]                    rdata1,
    output logic [INST_W-1:0]                    rdata2,
    output logic                                 rvalid,
    output logic [geo_tw(SETS, LINE_WORDS)-1:0]  rtag,
    input  logic                                 we,
    input  logic [geo_wo(LINE_WORDS)-1:0]        wword,
    input  logic [INST_W-1:0]                    wdata,
    input  logic                                 tag_we,
    input  logic [geo_tw(SETS, LINE_WORDS)-1:0]  wtag
);

    localparam int WO = geo_wo(LINE_WORDS);
    localparam int TW = geo_tw(SETS, LINE_WORDS);

    logic [SETS-1:0]   valid;
    logic [TW-1:0]     tags [SETS];
    logic [INST_W-1:0] data [SETS*LINE_WORDS];
    logic [WO-1:0]     rword2;

    // Bulk clear outranks a simultaneous fill so a pending invalidate is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            data[{idx, wword}] <= wdata;
        end
        if (tag_we) begin
            tags[idx] <= wtag;
        end
    end

    // The second word wraps inside the line; the top masks it off on the last word.
    assign rword2 = rword + 1'b1;
    assign rdata1 = data[{idx, rword}];
    assign rdata2 = data[{idx, rword2}];
    assign rvalid = valid[idx];
    assign rtag   = tags[idx];

endmodule

// File: rtl/icache_dual_fetch.sv
// Direct-mapped read-only instruction cache returning two sequential instructions per hit, with line refill.
module icache_dual_fetch
    import icache_dual_fetch_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rreq_i,
    input  logic [INST_ADDR_W-1:0] raddr_i,
    input  logic                   invalidate_i,
    output logic [INST_W-1:0]      inst1_o,
    output logic [INST_W-1:0]      inst2_o,
    output logic [INST_ADDR_W-1:0] inst1_addr_o,
    output logic [INST_ADDR_W-1:0] inst2_addr_o,
    output logic                   inst_valid_o,
    output logic                   inst2_valid_o,
    output logic                   stall_o,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic                   mem_rvalid_i,
    input  logic [INST_W-1:0]      mem_rdata_i
);

    localparam int WO = geo_wo(LINE_WORDS);
    localparam int IW = geo_iw(SETS);
    localparam int TW = geo_tw(SETS, LINE_WORDS);
    localparam logic [INST_ADDR_W-1:0] LINE_MASK = INST_ADDR_W'(LINE_WORDS * 4 - 1);

    state_t                 state, state_n;
    logic [WO-1:0]          cnt, cnt_n;
    logic                   inv_pend, inv_pend_n;
    logic [INST_ADDR_W-1:0] addr_q;
    logic                   latch, clr, we, tag_we, out_sel, hit, last;
    logic [INST_W-1:0]      rd1, rd2, cur_inst2;
    logic                   line_valid;
    logic [TW-1:0]          line_tag;
    logic [INST_W-1:0]      hold_inst1, hold_inst2;
    logic [INST_ADDR_W-1:0] hold_addr1, hold_addr2;

    icache_line_bank #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .idx    (addr_q[2+WO +: IW]),
        .rword  (addr_q[2 +: WO]),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .we     (we),
        .wword  (cnt),
        .wdata  (mem_rdata_i),
        .tag_we (tag_we),
        .wtag   (addr_q[INST_ADDR_W-1 -: TW])
    );

    assign hit       = line_valid && (line_tag == addr_q[INST_ADDR_W-1 -: TW]);
    assign last      = &addr_q[2 +: WO];
    assign cur_inst2 = last ? '0 : rd2;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        inv_pend_n = inv_pend;
        latch      = 1'b0;
        clr        = 1'b0;
        stall_o    = 1'b0;
        mem_req_o  = 1'b0;
        we         = 1'b0;
        tag_we     = 1'b0;
        out_sel    = 1'b0;
        case (state)
            ST_IDLE: begin
                latch   = rreq_i;
                clr     = invalidate_i;
                state_n = rreq_i ? ST_LOOKUP : ST_IDLE;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    out_sel = 1'b1;
                    latch   = rreq_i;
                    clr     = invalidate_i;
                    state_n = rreq_i ? ST_LOOKUP : ST_IDLE;
                end else begin
                    stall_o    = 1'b1;
                    inv_pend_n = inv_pend | invalidate_i;
                    state_n    = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                mem_req_o  = 1'b1;
                stall_o    = 1'b1;
                inv_pend_n = inv_pend | invalidate_i;
                if (mem_ack_i) begin
                    cnt_n   = '0;
                    state_n = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall_o    = 1'b1;
                inv_pend_n = inv_pend | invalidate_i;
                if (mem_rvalid_i) begin
                    we    = 1'b1;
                    cnt_n = cnt + 1'b1;
                    if (&cnt) begin
                        tag_we  = 1'b1;
                        state_n = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // Invalidates deferred during the refill take effect here, after the data is delivered.
                out_sel    = 1'b1;
                latch      = rreq_i;
                clr        = invalidate_i | inv_pend;
                inv_pend_n = 1'b0;
                state_n    = rreq_i ? ST_LOOKUP : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            inv_pend   <= 1'b0;
            hold_inst1 <= '0;
            hold_inst2 <= '0;
            hold_addr1 <= '0;
            hold_addr2 <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            inv_pend <= inv_pend_n;
            if (out_sel) begin
                hold_inst1 <= rd1;
                hold_inst2 <= cur_inst2;
                hold_addr1 <= addr_q;
                hold_addr2 <= addr_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            addr_q <= raddr_i & 32'hFFFF_FFFC;
        end
    end

    assign inst_valid_o  = out_sel;
    assign inst2_valid_o = out_sel && !last;
    assign inst1_o       = out_sel ? rd1 : hold_inst1;
    assign inst2_o       = out_sel ? cur_inst2 : hold_inst2;
    assign inst1_addr_o  = out_sel ? addr_q : hold_addr1;
    assign inst2_addr_o  = out_sel ? (addr_q + 32'd4) : hold_addr2;
    assign mem_addr_o    = mem_req_o ? (addr_q & ~LINE_MASK) : '0;

endmodule
